mole_spawner: RTL and testbench

Consumer of the LFSR random stream in the mole game. Samples the 9-bit random number to choose which of the 9 holes raises a mole, how long it stays up and how long the pause before the next mole lasts. Judges player hits against the active hole and emits one-cycle hit/miss pulses for the score and lives logic. Sits between the random generator, the keypad decoder and the display/score blocks.

---
 rtl/mole_spawner.sv | 122 ++++++++++++
 tb/tb_mole_spawner.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mole_spawner.sv
// Mole spawner: turns the LFSR stream into mole positions and up/gap durations,
// and judges keypad hits against the active hole.
module mole_spawner #(
  parameter int CLK_PER_MS = 1000,
  parameter int UP_MS      = 500,
  parameter int GAP_MS     = 200
) (
  input  logic       clk_1mhz,
  input  logic       rst,
  input  logic       enable,
  input  logic [8:0] rand_num,
  input  logic       hit_valid,
  input  logic [3:0] hit_hole,
  output logic [8:0] mole_onehot,
  output logic       mole_active,
  output logic [3:0] hole_idx,
  output logic       hit_pulse,
  output logic       miss_pulse,
  output logic [1:0] state_dbg
);

  // Handshake: hit_valid is a one-cycle strobe with no ready/backpressure; it is
  // consumed on the edge it is sampled, and only counts in UP on a matching hole.
  localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;

  typedef enum logic [1:0] {IDLE, GAP, PICK, UP} state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic [10:0]   ms_cnt;
  logic [10:0]   ms_last;

  logic          tick;
  logic          expire;
  logic [3:0]    h_mod;
  logic [3:0]    h_pick;
  logic [10:0]   gap_last;
  logic [10:0]   up_last;
  logic          hit_match;

  assign tick      = (presc == PW'(CLK_PER_MS - 1));
  assign expire    = tick && (ms_cnt == ms_last);
  assign h_mod     = (rand_num[3:0] >= 4'd9) ? rand_num[3:0] - 4'd9 : rand_num[3:0];
  // hole_idx doubles as the previous hole, so a repeat bumps to the next hole mod 9
  assign h_pick    = (h_mod != hole_idx) ? h_mod :
                     (h_mod == 4'd8)     ? 4'd0  : h_mod + 4'd1;
  assign gap_last  = 11'(GAP_MS) + {3'b000, rand_num[8:6], 5'b00000} - 11'd1;
  assign up_last   = 11'(UP_MS) + {2'b00, rand_num[8:4], 4'b0000} - 11'd1;
  assign hit_match = hit_valid && (hit_hole == hole_idx);
  assign state_dbg = state;

  always_ff @(posedge clk_1mhz or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      presc       <= '0;
      ms_cnt      <= '0;
      ms_last     <= '0;
      mole_onehot <= '0;
      mole_active <= 1'b0;
      hole_idx    <= 4'hF;
      hit_pulse   <= 1'b0;
      miss_pulse  <= 1'b0;
    end else begin
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      if (tick) begin
        presc  <= '0;
        ms_cnt <= ms_cnt + 11'd1;
      end else begin
        presc  <= presc + PW'(1);
      end

      if (!enable) begin
        state       <= IDLE;
        presc       <= '0;
        ms_cnt      <= '0;
        mole_onehot <= '0;
        mole_active <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state   <= GAP;
            ms_last <= gap_last;
            presc   <= '0;
            ms_cnt  <= '0;
          end
          GAP: begin
            if (expire) begin
              state  <= PICK;
              presc  <= '0;
              ms_cnt <= '0;
            end
          end
          PICK: begin
            state       <= UP;
            hole_idx    <= h_pick;
            mole_onehot <= 9'd1 << h_pick;
            mole_active <= 1'b1;
            ms_last     <= up_last;
            presc       <= '0;
            ms_cnt      <= '0;
          end
          UP: begin
            // A hit on the final cycle wins over the timeout
            if (hit_match || expire) begin
              hit_pulse   <= hit_match;
              miss_pulse  <= !hit_match;
              state       <= GAP;
              mole_onehot <= '0;
              mole_active <= 1'b0;
              ms_last     <= gap_last;
              presc       <= '0;
              ms_cnt      <= '0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mole_spawner.sv
// Bench for mole_spawner: cycle-countdown reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_mole_spawner;

  localparam int CPM = 4;
  localparam int UPM = 2;
  localparam int GPM = 1;

  logic       clk_1mhz  = 1'b0;
  logic       rst       = 1'b1;
  logic       enable    = 1'b1;
  logic [8:0] rand_num  = 9'h000;
  logic       hit_valid = 1'b0;
  logic [3:0] hit_hole  = 4'h0;
  logic [8:0] mole_onehot;
  logic       mole_active;
  logic [3:0] hole_idx;
  logic       hit_pulse;
  logic       miss_pulse;
  logic [1:0] state_dbg;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  mole_spawner #(.CLK_PER_MS(CPM), .UP_MS(UPM), .GAP_MS(GPM)) dut (
    .clk_1mhz   (clk_1mhz),
    .rst        (rst),
    .enable     (enable),
    .rand_num   (rand_num),
    .hit_valid  (hit_valid),
    .hit_hole   (hit_hole),
    .mole_onehot(mole_onehot),
    .mole_active(mole_active),
    .hole_idx   (hole_idx),
    .hit_pulse  (hit_pulse),
    .miss_pulse (miss_pulse),
    .state_dbg  (state_dbg)
  );

  // clock / reset block
  always #5 clk_1mhz = ~clk_1mhz;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference model: phase plus cycles remaining, derived from ms durations
  int         m_phase  = 0;  // 0 idle, 1 gap, 2 pick, 3 up
  int         m_left   = 0;
  int         m_hole   = 15;
  int         m_h      = 0;
  logic [8:0] m_onehot = 9'h000;
  logic       m_hit    = 1'b0;
  logic       m_miss   = 1'b0;

  function automatic int gap_cycles(input logic [8:0] r);
    return (GPM + int'(r[8:6]) * 32) * CPM;
  endfunction

  function automatic int up_cycles(input logic [8:0] r);
    return (UPM + int'(r[8:4]) * 16) * CPM;
  endfunction

  initial forever begin
    @(posedge clk_1mhz or posedge rst);
    if (rst) begin
      m_phase = 0; m_left = 0; m_hole = 15; m_onehot = 9'h000; m_hit = 1'b0; m_miss = 1'b0;
    end else begin
      m_hit = 1'b0;
      m_miss = 1'b0;
      if (!enable) begin
        m_phase = 0;
        m_onehot = 9'h000;
      end else begin
        case (m_phase)
          0: begin m_phase = 1; m_left = gap_cycles(rand_num); end
          1: begin m_left--; if (m_left == 0) m_phase = 2; end
          2: begin
            m_h = int'(rand_num[3:0]) % 9;
            if (m_h == m_hole) m_h = (m_h + 1) % 9;
            m_hole = m_h;
            m_onehot = 9'h001 << m_h;
            m_left = up_cycles(rand_num);
            m_phase = 3;
          end
          default: begin
            if (hit_valid && int'(hit_hole) == m_hole) begin
              m_hit = 1'b1; m_onehot = 9'h000; m_phase = 1; m_left = gap_cycles(rand_num);
            end else begin
              m_left--;
              if (m_left == 0) begin
                m_miss = 1'b1; m_onehot = 9'h000; m_phase = 1; m_left = gap_cycles(rand_num);
              end
            end
          end
        endcase
      end
    end
  end

  // scoreboard compare, once per cycle away from the active edge
  initial forever begin
    @(negedge clk_1mhz);
    if (chk_en && !rst) begin
      check("cyc_onehot", mole_onehot, m_onehot);
      check("cyc_active", mole_active, (m_onehot != 9'h000));
      check("cyc_hole", hole_idx, m_hole[3:0]);
      check("cyc_hit", hit_pulse, m_hit);
      check("cyc_miss", miss_pulse, m_miss);
    end
  end

  // driver tasks
  task automatic cyc(input int n);
    repeat (n) @(negedge clk_1mhz);
  endtask

  task automatic hit(input logic [3:0] h);
    hit_valid = 1'b1;
    hit_hole  = h;
    @(negedge clk_1mhz);
    hit_valid = 1'b0;
    hit_hole  = 4'h0;
  endtask

  int n_up;

  initial begin
    // reset with enable high
    cyc(1);
    check("rst_onehot", mole_onehot, 9'h000);
    check("rst_active", mole_active, 1'b0);
    check("rst_hole", hole_idx, 4'hF);
    check("rst_hit", hit_pulse, 1'b0);
    check("rst_miss", miss_pulse, 1'b0);
    enable = 1'b0;
    cyc(1);
    rst = 1'b0;
    chk_en = 1'b1;
    cyc(50);
    check("idle_onehot", mole_onehot, 9'h000);
    check("idle_hole", hole_idx, 4'hF);

    // basic timeout: GAP 4, PICK 1, UP 8, miss
    rand_num = 9'h000;
    enable = 1'b1;
    cyc(5);
    check("first_mole_not_early", mole_active, 1'b0);
    cyc(1);
    check("first_onehot", mole_onehot, 9'h001);
    check("first_hole", hole_idx, 4'd0);
    cyc(7);
    check("up_last_cycle", mole_active, 1'b1);
    cyc(1);
    check("timeout_miss", miss_pulse, 1'b1);
    check("timeout_clear", mole_onehot, 9'h000);

    // no-repeat: same rand gives hole 1 next
    cyc(5);
    check("norepeat_onehot", mole_onehot, 9'h002);
    check("norepeat_hole", hole_idx, 4'd1);

    // wrong hole ignored, then correct hit
    cyc(2);
    hit(4'd5);
    check("wrong_hit_pulse", hit_pulse, 1'b0);
    check("wrong_hit_active", mole_active, 1'b1);
    hit(4'd1);
    check("hit_pulse", hit_pulse, 1'b1);
    check("hit_clear", mole_onehot, 9'h000);
    cyc(4);
    check("gap_after_hit", mole_active, 1'b0);
    cyc(1);
    check("after_hit_onehot", mole_onehot, 9'h001);

    // hit on the final UP cycle
    cyc(7);
    hit(4'd0);
    check("final_hit_pulse", hit_pulse, 1'b1);
    check("final_hit_nomiss", miss_pulse, 1'b0);
    rand_num = 9'h01C;
    cyc(1);
    check("final_hit_nomiss_later", miss_pulse, 1'b0);

    // rand 0x01C: hole 12-9=3, up time (2+16)*4
    cyc(4);
    check("mod_hole", hole_idx, 4'd3);
    check("mod_onehot", mole_onehot, 9'h008);
    n_up = 0;
    while (n_up < 200 && !miss_pulse) begin
      if (mole_active) n_up++;
      cyc(1);
    end
    check("up_time_72", n_up, 72);

    // rand 0x00C after hole 3: bumped to 4
    rand_num = 9'h00C;
    cyc(5);
    check("bump_hole", hole_idx, 4'd4);

    // drop enable with a simultaneous correct hit
    cyc(2);
    enable = 1'b0;
    hit_valid = 1'b1;
    hit_hole = 4'd4;
    cyc(1);
    hit_valid = 1'b0;
    check("abort_hit_clear", mole_onehot, 9'h000);
    check("abort_hit_nopulse", hit_pulse, 1'b0);
    check("abort_hit_hole", hole_idx, 4'd4);
    cyc(5);
    check("abort_idle", mole_active, 1'b0);

    // drop enable without a hit
    rand_num = 9'h000;
    enable = 1'b1;
    cyc(6);
    check("reen_hole", hole_idx, 4'd0);
    cyc(2);
    enable = 1'b0;
    cyc(1);
    check("abort_clear", mole_active, 1'b0);
    check("abort_hole", hole_idx, 4'd0);
    check("abort_nomiss", miss_pulse, 1'b0);

    // async reset mid-UP
    enable = 1'b1;
    cyc(6);
    check("pre_rst_onehot", mole_onehot, 9'h002);
    cyc(2);
    #2 rst = 1'b1;
    #1;
    check("rst_up_onehot", mole_onehot, 9'h000);
    check("rst_up_active", mole_active, 1'b0);
    check("rst_up_hole", hole_idx, 4'hF);
    cyc(1);
    rst = 1'b0;

    // async reset mid-GAP
    cyc(6);
    check("post_rst_hole", hole_idx, 4'd0);
    cyc(8);
    check("post_rst_miss", miss_pulse, 1'b1);
    cyc(2);
    #2 rst = 1'b1;
    #1;
    check("rst_gap_hole", hole_idx, 4'hF);
    check("rst_gap_miss", miss_pulse, 1'b0);
    cyc(1);
    rst = 1'b0;
    cyc(3);
    enable = 1'b0;
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
